// File: rtl/stream_demux_1_4.sv
// ---------------------------------------------------------------------------
// stream_demux_1_4
// Registered 1-to-4 packet demultiplexer. One valid/ready input stream is
// steered packet-by-packet to one of four output channels; the destination is
// taken from in_sel on the first beat of each packet and held until the beat
// carrying in_last. Each channel owns a one-deep output register, so latency
// is one cycle and a stalled channel only blocks the input while the current
// route points at it.
//
// Ports
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   in_data    in   DATA_W     input beat
//   in_sel     in   2          destination channel, sampled on first beat
//   in_last    in   1          final beat of a packet
//   in_valid   in   1          input beat present
//   in_ready   out  1          beat accepted this cycle (combinational)
//   out_data   out  4*DATA_W   channel i at [i*DATA_W +: DATA_W]
//   out_last   out  4          per-channel last flag
//   out_valid  out  4          per-channel beat present
//   out_ready  in   4          per-channel downstream ready
//   busy       out  1          a packet is open
//   route      out  2          current destination (combinational)
// ---------------------------------------------------------------------------
module stream_demux_1_4 #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned N_CH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [1:0]               in_sel,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_last,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic                     busy,
    output logic [1:0]               route
);

    localparam int unsigned SEL_W = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                          state_q;
    state_t                          state_d;
    logic [SEL_W-1:0]                locked_q;
    logic [SEL_W-1:0]                locked_d;

    logic [N_CH-1:0][DATA_W-1:0]     data_q;
    logic [N_CH-1:0]                 last_q;
    logic [N_CH-1:0]                 valid_q;

    logic                            accept;
    logic [N_CH-1:0]                 load;

    // Destination for the current beat: live select when idle, lock otherwise.
    assign route = (state_q == ST_IDLE) ? in_sel : locked_q;

    // Only the routed channel's occupancy can stall the input.
    assign in_ready = !valid_q[route] | out_ready[route];
    assign accept   = in_valid & in_ready;

    // One-hot load strobe toward the routed channel.
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            load[i] = accept && (route == SEL_W'(i));
        end
    end

    // Packet framing FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            locked_q <= '0;
        end else begin
            state_q  <= state_d;
            locked_q <= locked_d;
        end
    end

    // Packet framing FSM: next state and destination lock.
    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !in_last) begin
                    state_d  = ST_BUSY;
                    locked_d = in_sel;
                end
            end
            ST_BUSY: begin
                if (accept && in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-channel output registers; a load wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            last_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (load[i]) begin
                    data_q[i]  <= in_data;
                    last_q[i]  <= in_last;
                    valid_q[i] <= 1'b1;
                end else if (valid_q[i] && out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == ST_BUSY);

endmodule
